// File: rtl/apple_manager.sv
// Apple placement and scoring for the snake game: requests candidates, rejects
// occupied or head cells, tracks eats with a saturating BCD score.
module apple_manager #(
    parameter int unsigned MAX_RETRY = 32,
    parameter int unsigned SCORE_MAX = 99
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic [3:0]           head_x,
    input  logic [3:0]           head_y,
    input  logic [15:0][15:0]    GrnPixels,
    input  logic [3:0]           cand_x,
    input  logic [3:0]           cand_y,
    input  logic                 cand_valid,
    output logic                 req,
    output logic [3:0]           apple_x,
    output logic [3:0]           apple_y,
    output logic                 apple_valid,
    output logic [15:0][15:0]    RedPixels,
    output logic                 grow,
    output logic [7:0]           score,
    output logic                 board_full
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ    = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] PLACED = 3'd3;
    localparam logic [2:0] FULL   = 3'd4;

    localparam int unsigned RW = $clog2(MAX_RETRY) + 1;
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

    // Saturation point held in the same BCD encoding as the score register.
    localparam logic [7:0] SCORE_SAT = {4'(SCORE_MAX / 10), 4'(SCORE_MAX % 10)};

    logic [2:0]    state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    score_d;
    logic [3:0]    apple_x_d, apple_y_d;
    logic          grow_d;

    logic cand_free;
    logic cand_on_head;
    logic accept;
    logic eat;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        logic [7:0] r;
        if (s >= SCORE_SAT) begin
            r = s;
        end else if (s[3:0] == 4'd9) begin
            r = {s[7:4] + 4'd1, 4'd0};
        end else begin
            r = {s[7:4], s[3:0] + 4'd1};
        end
        return r;
    endfunction

    always_comb begin
        cand_free    = ~GrnPixels[cand_x][cand_y];
        cand_on_head = (cand_x == head_x) && (cand_y == head_y);
        accept       = cand_valid && cand_free && !cand_on_head;
        eat          = tick && (head_x == apple_x) && (head_y == apple_y);
    end

    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        score_d   = score;
        apple_x_d = apple_x;
        apple_y_d = apple_y;
        grow_d    = 1'b0;

        if (start) begin
            // Restart wins over any concurrent tick, eat or candidate.
            state_d = REQ;
            retry_d = '0;
            score_d = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                end
                REQ: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (cand_valid) begin
                        if (accept) begin
                            apple_x_d = cand_x;
                            apple_y_d = cand_y;
                            retry_d   = '0;
                            state_d   = PLACED;
                        end else if (retry_q >= RETRY_LAST) begin
                            state_d = FULL;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = REQ;
                        end
                    end
                end
                PLACED: begin
                    if (eat) begin
                        grow_d  = 1'b1;
                        score_d = bcd_inc(score);
                        state_d = REQ;
                    end
                end
                FULL: begin
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            retry_q <= '0;
            score   <= 8'h00;
            apple_x <= 4'd0;
            apple_y <= 4'd0;
            grow    <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            score   <= score_d;
            apple_x <= apple_x_d;
            apple_y <= apple_y_d;
            grow    <= grow_d;
        end
    end

    always_comb begin
        req         = (state_q == REQ);
        apple_valid = (state_q == PLACED);
        board_full  = (state_q == FULL);
    end

    always_comb begin
        RedPixels                   = '0;
        RedPixels[apple_x][apple_y] = apple_valid;
    end

endmodule

// File: doc/apple_manager.md
APPLE_MANAGER -- requirements
Module: apple_manager

Interface
REQ-001 Parameter MAX_RETRY, default 32: the number of consecutive rejected candidates before the board is declared full.
REQ-002 Parameter SCORE_MAX, default 99: the score saturation value, expressed as two BCD digits.
REQ-003 clk  in  1  system clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
REQ-005 start  in  1  one-cycle pulse that starts a new game.
REQ-006 tick  in  1  one-cycle pulse marking a snake step; head_x and head_y are valid in this cycle.
REQ-007 head_x, head_y  in  4 each  coordinates of the snake head.
REQ-008 GrnPixels  in  [15:0][15:0]  snake occupancy, indexed [x][y]; 1 = occupied.
REQ-009 cand_x, cand_y  in  4 each  candidate coordinate from the apple generator.
REQ-010 cand_valid  in  1  candidate is valid in this cycle.
REQ-011 req  out  1  requests a new candidate from the generator.
REQ-012 apple_x, apple_y  out  4 each  coordinates of the placed apple.
REQ-013 apple_valid  out  1  an apple is currently placed.
REQ-014 RedPixels  out  [15:0][15:0]  one-hot apple plane; all zero when apple_valid==0.
REQ-015 grow  out  1  one-cycle pulse telling the snake to lengthen.
REQ-016 score  out  8  two BCD digits, [7:4] tens and [3:0] units.
REQ-017 board_full  out  1  no free cell was found.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, REQ, WAIT, PLACED and FULL; every output except RedPixels SHALL be registered or a decode of the current state.
REQ-019 IDLE: start -> REQ, clear score, clear retry count; all other inputs are ignored.
REQ-020 REQ: req==1 for exactly this one cycle; unconditional transition -> WAIT.
REQ-021 WAIT: while cand_valid==0, remain in WAIT with req==0.
REQ-022 A candidate SHALL be accepted when cand_valid==1, GrnPixels[cand_x][cand_y]==0 and the candidate differs from (head_x, head_y): latch apple_x/apple_y, clear retry count, go to PLACED; apple_valid==1 from the next cycle.
REQ-023 A candidate SHALL be rejected otherwise: if retry==MAX_RETRY-1, go to FULL; else increment retry and go to REQ.
REQ-024 PLACED: tick==1 with (head_x, head_y)==(apple_x, apple_y) is an eat; in the following cycle grow==1, score increments, apple_valid==0 and state is REQ.
REQ-025 PLACED: tick with a head mismatch changes nothing.
REQ-026 FULL: board_full==1 and apple_valid==0; stays in FULL until start or reset.
REQ-027 start in any non-IDLE state SHALL restart the game: score 0, retry 0, apple_valid 0, go to REQ, grow 0.
REQ-028 start takes priority over a simultaneous tick, eat or cand_valid.
REQ-029 Score SHALL be a BCD increment with units 9 -> 0 and a tens carry, saturating at SCORE_MAX with no wrap.
REQ-030 The retry counter SHALL be $clog2(MAX_RETRY)+1 bits wide and SHALL never wrap.
REQ-031 cand_valid outside WAIT SHALL be ignored.
REQ-032 RedPixels[apple_x][apple_y] SHALL equal apple_valid; all other bits SHALL be 0.

Reset
REQ-033 On reset==0 at a posedge: state IDLE, req 0, apple_x 0, apple_y 0, apple_valid 0, RedPixels all zero, grow 0, score 8'h00, board_full 0, retry 0.
REQ-034 Reset SHALL override start and every other input, including in the middle of WAIT or PLACED.

Verification
REQ-035 Reset, then start, then cand (12,12) valid with an empty grid -> req high 1 cycle after start; apple_valid=1 and apple (12,12) the cycle after the candidate; RedPixels[12][12]=1 only.
REQ-036 GrnPixels[5][6]=1, candidates (5,6) then (7,7) -> first rejected, req reasserted next cycle; apple placed at (7,7).
REQ-037 Apple at (3,4), tick with head (3,4) -> next cycle grow=1 for one cycle, score 01, req=1, apple_valid=0.
REQ-038 Score preloaded to 99 via repeated eats, then one more eat -> score stays 8'h99; score 09 plus one eat -> 8'h10.
REQ-039 Full grid, MAX_RETRY rejected candidates -> board_full=1 and state FULL; then start -> board_full=0, req=1, score 00.
REQ-040 reset=0 asserted while in WAIT with cand_valid=1 -> all outputs at reset values on the next cycle; no apple placed.
